// File: rtl/float_wb_scheduler.sv
// Float register-file write-port arbiter with a busy scoreboard.
// Round-robin result writeback plus RAW/WAW stall generation for issue.
module float_wb_scheduler #(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clken,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*5-1:0] req_rd,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [4:0]        rdi,
    output logic [DW-1:0]     write_data,
    output logic              reg_write,
    input  logic              issue_valid,
    input  logic [14:0]       issue_rs,
    input  logic [2:0]        issue_rs_used,
    input  logic [4:0]        issue_rd,
    input  logic              issue_rd_used,
    output logic              issue_stall,
    output logic [31:0]       busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] rr_q, rr_d;
    logic [31:0]   busy_q, busy_d;
    logic [4:0]    rdi_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;

    logic          gvld;
    logic [IW-1:0] gidx;
    logic [IW:0]   s;
    logic [4:0]    g_rd;
    logic [DW-1:0] g_dat;
    logic [31:0]   wr_oh, eb;
    logic          haz;

    // Search starts at rr and wraps modulo NREQ.
    always_comb begin
        gvld = 1'b0;
        gidx = '0;
        s    = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = {1'b0, rr_q} + (IW+1)'(k);
            if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
            if (!gvld && req_valid[s[IW-1:0]]) begin
                gvld = 1'b1;
                gidx = s[IW-1:0];
            end
        end
    end

    always_comb begin
        g_rd  = '0;
        g_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gvld && gidx == IW'(i)) begin
                g_rd  = req_rd[i*5 +: 5];
                g_dat = req_data[i*DW +: DW];
            end
        end
    end

    assign rr_d = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (gvld && clken && rstn) req_ready[gidx] = 1'b1;
    end

    // A register written this cycle is forwarded by the register file.
    assign wr_oh = we_q ? (32'd1 << rdi_q) : 32'd0;
    assign eb    = busy_q & ~wr_oh;

    always_comb begin
        haz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (issue_rs_used[k] && eb[issue_rs[k*5 +: 5]]) haz = 1'b1;
        end
        if (issue_rd_used && eb[issue_rd]) haz = 1'b1;
    end

    assign issue_stall = ~clken | (issue_valid & haz);

    always_comb begin
        busy_d = busy_q;
        if (we_q) busy_d[rdi_q] = 1'b0;
        if (issue_valid && issue_rd_used && !issue_stall) busy_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q    <= '0;
            busy_q  <= '0;
            rdi_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (clken) begin
            busy_q <= busy_d;
            we_q   <= gvld;
            if (gvld) begin
                rdi_q   <= g_rd;
                wdata_q <= g_dat;
                rr_q    <= rr_d;
            end
        end
    end

    assign rdi        = rdi_q;
    assign write_data = wdata_q;
    assign reg_write  = we_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_float_wb_scheduler.sv
// Bench for float_wb_scheduler: directed scenarios plus a randomized
// run against a queue-free behavioural model of arbitration and scoreboard.
module tb_float_wb_scheduler;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clken = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_rd = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_ready;
    logic [4:0]  rdi;
    logic [31:0] write_data;
    logic        reg_write;
    logic        issue_valid = 1'b0;
    logic [14:0] issue_rs = '0;
    logic [2:0]  issue_rs_used = '0;
    logic [4:0]  issue_rd = '0;
    logic        issue_rd_used = 1'b0;
    logic        issue_stall;
    logic [31:0] busy;

    int vectors = 0;
    int miscompares = 0;

    bit [31:0] m_busy;
    int        m_rr;
    bit        m_we;
    bit [4:0]  m_rdi;
    bit [31:0] m_wd;

    float_wb_scheduler #(.NREQ(3), .DW(32)) dut (
        .clk(clk), .rstn(rstn), .clken(clken),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready), .rdi(rdi), .write_data(write_data),
        .reg_write(reg_write), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
        .issue_rd(issue_rd), .issue_rd_used(issue_rd_used),
        .issue_stall(issue_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_rr + k) % 3;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit exp_stall();
        bit [31:0] eb;
        eb = m_busy;
        if (m_we) eb[m_rdi] = 1'b0;
        if (!clken) return 1'b1;
        if (!issue_valid) return 1'b0;
        for (int k = 0; k < 3; k++)
            if (issue_rs_used[k] && eb[issue_rs[k*5 +: 5]]) return 1'b1;
        return issue_rd_used && eb[issue_rd];
    endfunction

    task automatic model_reset();
        m_busy = '0; m_rr = 0; m_we = 0; m_rdi = '0; m_wd = '0;
    endtask

    task automatic model_update();
        int g;
        bit st;
        if (!clken || !rstn) return;
        g  = exp_grant();
        st = exp_stall();
        if (m_we) m_busy[m_rdi] = 1'b0;
        if (issue_valid && issue_rd_used && !st) m_busy[issue_rd] = 1'b1;
        if (g >= 0) begin
            m_we = 1; m_rdi = req_rd[g*5 +: 5]; m_wd = req_data[g*32 +: 32];
            m_rr = (g + 1) % 3;
        end else begin
            m_we = 0;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit [4:0] rd, input bit [31:0] d);
        req_valid[i] = v;
        req_rd[i*5 +: 5] = rd;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic set_issue(input bit v, input bit [14:0] rs, input bit [2:0] used,
                             input bit [4:0] rd, input bit rdu);
        issue_valid = v; issue_rs = rs; issue_rs_used = used;
        issue_rd = rd; issue_rd_used = rdu;
    endtask

    task automatic test_reset();
        req_valid = 3'b111;
        #2;
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
        vectors++; if (reg_write !== 1'b0) begin miscompares++; $display("FAIL rst_we got=%b exp=0", reg_write); end
        vectors++; if (busy !== 32'd0) begin miscompares++; $display("FAIL rst_busy got=%h exp=0", busy); end
        vectors++; if (rdi !== 5'd0 || write_data !== 32'd0) begin miscompares++; $display("FAIL rst_wb got=%0d/%h exp=0/0", rdi, write_data); end
        req_valid = '0;
        model_reset();
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rr_burst();
        bit [31:0] d [3];
        d[0] = 32'hAAAA_0001; d[1] = 32'hBBBB_0002; d[2] = 32'hCCCC_0003;
        for (int i = 0; i < 3; i++) set_req(i, 1, 5'(i + 1), d[i]);
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++; if (req_ready !== 3'(1 << i)) begin miscompares++; $display("FAIL burst_ready%0d got=%b exp=%b", i, req_ready, 3'(1 << i)); end
            tick();
            set_req(i, 0, 5'(i + 1), d[i]);
            vectors++;
            if (reg_write !== 1'b1 || rdi !== 5'(i + 1) || write_data !== d[i]) begin
                miscompares++;
                $display("FAIL burst_wr%0d got=%b/%0d/%h exp=1/%0d/%h", i, reg_write, rdi, write_data, i + 1, d[i]);
            end
        end
        #2;
        vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL burst_idle_ready got=%b exp=000", req_ready); end
        tick();
        vectors++; if (reg_write !== 1'b0 || rdi !== 5'd3) begin miscompares++; $display("FAIL burst_idle_wb got=%b/%0d exp=0/3", reg_write, rdi); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            set_req(2, 1, 5'(10 + n), 32'h2000 + 32'(n));
            #2;
            vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL b2b_ready%0d got=%b exp=100", n, req_ready); end
            tick();
            vectors++;
            if (reg_write !== 1'b1 || rdi !== 5'(10 + n) || write_data !== 32'h2000 + 32'(n)) begin
                miscompares++;
                $display("FAIL b2b_wr%0d got=%b/%0d/%h exp=1/%0d/%h", n, reg_write, rdi, write_data, 10 + n, 32'h2000 + 32'(n));
            end
        end
        set_req(0, 1, 5'd20, 32'hD0D0_0000);
        #2;
        vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL rr0_first got=%b exp=001", req_ready); end
        tick();
        set_req(0, 0, 5'd0, 32'd0);
        vectors++; if (rdi !== 5'd20) begin miscompares++; $display("FAIL rr0_rdi got=%0d exp=20", rdi); end
        #2;
        vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL rr0_then2 got=%b exp=100", req_ready); end
        tick();
        set_req(2, 0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_forward();
        set_issue(1, 15'd0, 3'b000, 5'd5, 1);
        #2;
        vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL fwd_issue got=%b exp=0", issue_stall); end
        tick();
        vectors++; if (busy[5] !== 1'b1) begin miscompares++; $display("FAIL fwd_set got=%b exp=1", busy[5]); end
        set_issue(1, 15'd5, 3'b001, 5'd0, 0);
        #2;
        vectors++; if (issue_stall !== 1'b1) begin miscompares++; $display("FAIL fwd_raw got=%b exp=1", issue_stall); end
        tick();
        set_req(1, 1, 5'd5, 32'h5555_5555);
        #2;
        vectors++; if (req_ready !== 3'b010 || issue_stall !== 1'b1) begin miscompares++; $display("FAIL fwd_grant got=%b/%b exp=010/1", req_ready, issue_stall); end
        tick();
        set_req(1, 0, 5'd0, 32'd0);
        #2;
        vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL fwd_bypass got=%b exp=0", issue_stall); end
        tick();
        vectors++; if (busy[5] !== 1'b0) begin miscompares++; $display("FAIL fwd_clear got=%b exp=0", busy[5]); end
        set_issue(0, 15'd0, 3'b000, 5'd0, 0);
    endtask

    task automatic test_set_wins();
        set_req(0, 1, 5'd7, 32'h7777_0007);
        #2;
        vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL sw_grant got=%b exp=001", req_ready); end
        tick();
        set_req(0, 0, 5'd0, 32'd0);
        set_issue(1, 15'd0, 3'b000, 5'd7, 1);
        #2;
        vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL sw_issue got=%b exp=0", issue_stall); end
        tick();
        vectors++; if (busy[7] !== 1'b1) begin miscompares++; $display("FAIL sw_busy got=%b exp=1", busy[7]); end
        set_issue(1, 15'(7 << 5), 3'b010, 5'd0, 0);
        #2;
        vectors++; if (issue_stall !== 1'b1) begin miscompares++; $display("FAIL sw_use got=%b exp=1", issue_stall); end
        tick();
    endtask

    task automatic test_waw();
        set_issue(1, 15'd0, 3'b000, 5'd9, 1);
        #2;
        tick();
        vectors++; if (busy[9] !== 1'b1) begin miscompares++; $display("FAIL waw_set got=%b exp=1", busy[9]); end
        #2;
        vectors++; if (issue_stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall got=%b exp=1", issue_stall); end
        tick();
        set_issue(1, {5'd9, 5'd9, 5'd9}, 3'b000, 5'd9, 0);
        #2;
        vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL waw_nouse got=%b exp=0", issue_stall); end
        tick();
        set_issue(0, 15'd0, 3'b000, 5'd9, 1);
        #2;
        vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL waw_novalid got=%b exp=0", issue_stall); end
        tick();
    endtask

    task automatic test_clken_freeze();
        int g;
        set_req(0, 1, 5'd12, 32'h1212_1212);
        set_req(2, 1, 5'd13, 32'h1313_1313);
        set_issue(1, 15'd0, 3'b000, 5'd11, 1);
        clken = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #2;
            vectors++; if (req_ready !== 3'b000 || issue_stall !== 1'b1) begin miscompares++; $display("FAIL ck_comb%0d got=%b/%b exp=000/1", n, req_ready, issue_stall); end
            tick();
            vectors++;
            if (reg_write !== m_we || rdi !== m_rdi || write_data !== m_wd || busy !== m_busy) begin
                miscompares++;
                $display("FAIL ck_hold%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", n, reg_write, rdi, write_data, busy, m_we, m_rdi, m_wd, m_busy);
            end
        end
        clken = 1'b1;
        #2;
        g = exp_grant();
        vectors++; if (g < 0 || req_ready !== 3'(1 << g)) begin miscompares++; $display("FAIL ck_resume got=%b exp_idx=%0d", req_ready, g); end
        tick();
    endtask

    task automatic test_async_reset();
        set_req(1, 1, 5'd14, 32'h1414_1414);
        #2;
        rstn = 1'b0;
        #1;
        vectors++; if (reg_write !== 1'b0 || busy !== 32'd0) begin miscompares++; $display("FAIL arst_now got=%b/%h exp=0/0", reg_write, busy); end
        vectors++; if (req_ready !== 3'b000 || rdi !== 5'd0 || write_data !== 32'd0) begin miscompares++; $display("FAIL arst_out got=%b/%0d/%h exp=000/0/0", req_ready, rdi, write_data); end
        req_valid = '0;
        set_issue(0, 15'd0, 3'b000, 5'd0, 0);
        model_reset();
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int g;
        bit st;
        bit [2:0] er;
        for (int n = 0; n < 400; n++) begin
            clken = ($urandom % 10) != 0;
            for (int i = 0; i < 3; i++)
                if (!req_valid[i] && ($urandom % 2))
                    set_req(i, 1, 5'($urandom % 8), $urandom);
            set_issue(1'($urandom % 2), 15'({5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8)}),
                      3'($urandom), 5'($urandom % 8), 1'($urandom % 2));
            #2;
            g  = exp_grant();
            st = exp_stall();
            er = (clken && g >= 0) ? 3'(1 << g) : 3'b000;
            vectors++; if (req_ready !== er) begin miscompares++; $display("FAIL rnd_ready%0d got=%b exp=%b", n, req_ready, er); end
            vectors++; if (issue_stall !== st) begin miscompares++; $display("FAIL rnd_stall%0d got=%b exp=%b", n, issue_stall, st); end
            tick();
            if (er != 3'b000) req_valid[g] = 1'b0;
            vectors++;
            if (reg_write !== m_we || rdi !== m_rdi || write_data !== m_wd || busy !== m_busy) begin
                miscompares++;
                $display("FAIL rnd_state%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", n, reg_write, rdi, write_data, busy, m_we, m_rdi, m_wd, m_busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rr_burst();
        test_back_to_back();
        test_forward();
        test_set_wins();
        test_waw();
        test_clken_freeze();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
